// File: rtl/bus_master_tx.sv
// Initiator-side serial bus port: arbitrates for the bus, serialises slave ID, address and write
// data LSB first, deserialises read data, and handles split retry and ack timeout.
module bus_master_tx #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              REQ,
    input  logic              RW,
    input  logic [1:0]        SLV_ID,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              GRANT,
    input  logic              SPLIT,
    input  logic              S_ACK,
    input  logic              S_DIN,
    input  logic              S_DVALID,
    output logic              B_BREQ,
    output logic              B_UTIL,
    output logic              A_ADD,
    output logic              B_BUS_OUT,
    output logic              B_MODE,
    output logic [DATA_W-1:0] RDATA,
    output logic              DONE,
    output logic              ERR,
    output logic              BUSY
);

    localparam int unsigned MaxW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CntW = $clog2(MaxW) + 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT);
    localparam int unsigned RtW  = $clog2(RETRY_MAX + 1);

    typedef enum logic [3:0] {
        StIdle, StReqBus, StSel, StAddr, StSplitWait,
        StWdata, StAckWait, StRdWait, StRdData, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [RtW-1:0]    retry_q, retry_d;
    logic [1:0]        slv_q, slv_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fail_q, fail_d;
    logic              idle_err;

    logic breq_q, breq_d, util_q, util_d, aadd_q, aadd_d, bit_q, bit_d;
    logic done_q, done_d, err_q, err_d, busy_q, busy_d;

    logic [1:0]        slv_sh;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] wdata_sh;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tmo_q   <= '0;
            retry_q <= '0;
            slv_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
            fail_q  <= 1'b0;
            breq_q  <= 1'b0;
            util_q  <= 1'b0;
            aadd_q  <= 1'b0;
            bit_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
            slv_q   <= slv_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
            fail_q  <= fail_d;
            breq_q  <= breq_d;
            util_q  <= util_d;
            aadd_q  <= aadd_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;
        slv_d    = slv_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rw_d     = rw_q;
        rdata_d  = rdata_q;
        fail_d   = fail_q;
        idle_err = 1'b0;
        case (state_q)
            StIdle: begin
                retry_d = '0;
                fail_d  = 1'b0;
                if (REQ) begin
                    slv_d   = SLV_ID;
                    addr_d  = MEM_ADDR;
                    wdata_d = WDATA;
                    rw_d    = RW;
                    if (SLV_ID == 2'd0) idle_err = 1'b1;
                    else                state_d  = StReqBus;
                end
            end
            StReqBus: if (GRANT) state_d = StSel;
            StSel: begin
                if (cnt_q == CntW'(1)) state_d = StAddr;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            StAddr: begin
                if (cnt_q == '0 && SPLIT) begin
                    state_d = StSplitWait;
                    retry_d = retry_q + 1'b1;
                end else if (cnt_q == CntW'(ADDR_W - 1)) begin
                    state_d = rw_q ? StWdata : StRdWait;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSplitWait: begin
                if (retry_q == RtW'(RETRY_MAX)) begin
                    state_d = StDone;
                    fail_d  = 1'b1;
                end else if (!SPLIT) begin
                    state_d = StReqBus;
                end
            end
            StWdata: begin
                if (cnt_q == CntW'(DATA_W - 1)) state_d = StAckWait;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            StAckWait, StRdWait: begin
                // Ack takes priority over a simultaneous timeout.
                if (S_ACK) begin
                    state_d = (state_q == StAckWait) ? StDone : StRdData;
                    fail_d  = 1'b0;
                end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                    state_d = StDone;
                    fail_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StRdData: begin
                if (S_DVALID) begin
                    rdata_d = (rdata_q & ~(DATA_W'(1) << cnt_q)) | (DATA_W'(S_DIN) << cnt_q);
                    tmo_d   = '0;
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        state_d = StDone;
                        fail_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                    state_d = StDone;
                    fail_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                retry_d = '0;
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
            tmo_d = '0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        slv_sh   = slv_d >> cnt_d;
        addr_sh  = addr_d >> cnt_d;
        wdata_sh = wdata_d >> cnt_d;
        breq_d   = 1'b0;
        util_d   = 1'b0;
        aadd_d   = 1'b0;
        bit_d    = 1'b0;
        case (state_d)
            StReqBus, StAckWait, StRdWait, StRdData: breq_d = 1'b1;
            StSel: begin
                breq_d = 1'b1;
                util_d = 1'b1;
                aadd_d = 1'b1;
                bit_d  = slv_sh[0];
            end
            StAddr: begin
                breq_d = 1'b1;
                util_d = 1'b1;
                bit_d  = addr_sh[0];
            end
            StWdata: begin
                breq_d = 1'b1;
                util_d = 1'b1;
                bit_d  = wdata_sh[0];
            end
            default: ;
        endcase
        done_d = (state_d == StDone) || idle_err;
        err_d  = ((state_d == StDone) && fail_d) || idle_err;
        busy_d = (state_d != StIdle);
    end

    assign B_BREQ    = breq_q;
    assign B_UTIL    = util_q;
    assign A_ADD     = aadd_q;
    assign B_BUS_OUT = bit_q;
    assign B_MODE    = rw_q;
    assign RDATA     = rdata_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_bus_master_tx.sv
// Bench for bus_master_tx: reactive arbiter/slave driver, table of directed transactions,
// randomized transactions against an arithmetic timing model, plus idle-error and reset sequences.
module tb_bus_master_tx;

    localparam int RetryMax = 3;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        REQ, RW, GRANT, SPLIT, S_ACK, S_DIN, S_DVALID;
    logic [1:0]  SLV_ID;
    logic [11:0] MEM_ADDR;
    logic [7:0]  WDATA, RDATA;
    logic        B_BREQ, B_UTIL, A_ADD, B_BUS_OUT, B_MODE, DONE, ERR, BUSY;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    bus_master_tx #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(64), .RETRY_MAX(3)) dut (
        .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .RW(RW), .SLV_ID(SLV_ID), .MEM_ADDR(MEM_ADDR),
        .WDATA(WDATA), .GRANT(GRANT), .SPLIT(SPLIT), .S_ACK(S_ACK), .S_DIN(S_DIN),
        .S_DVALID(S_DVALID), .B_BREQ(B_BREQ), .B_UTIL(B_UTIL), .A_ADD(A_ADD),
        .B_BUS_OUT(B_BUS_OUT), .B_MODE(B_MODE), .RDATA(RDATA), .DONE(DONE), .ERR(ERR),
        .BUSY(BUSY)
    );

    // ack >= 64 means the slave never acks; gaps holds 2-bit idle counts before each read bit.
    typedef struct {
        bit          rw;
        logic [1:0]  slv;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdat;
        int          gdelay;
        int          ack;
        int          split_n;
        int          hold;
        logic [15:0] gaps;
        bit          exp_err;
        int          exp_done;
    } txn_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic txn_t mk(bit rw, logic [1:0] slv, logic [11:0] addr, logic [7:0] wd,
                                logic [7:0] rd, int gd, int ack, int sn, int hold,
                                logic [15:0] gaps, bit e_err, int e_done);
        txn_t t;
        t.rw = rw; t.slv = slv; t.addr = addr; t.wdata = wd; t.rdat = rd; t.gdelay = gd;
        t.ack = ack; t.split_n = sn; t.hold = hold; t.gaps = gaps;
        t.exp_err = e_err; t.exp_done = e_done;
        return t;
    endfunction

    // Completion timing measured from the first cycle after the last serial bit.
    function automatic txn_t model(input txn_t t);
        int sum = 0;
        for (int j = 0; j < 8; j++) sum += int'((t.gaps >> (2 * j)) & 16'd3);
        if (t.split_n >= RetryMax) begin
            t.exp_err = 1'b1; t.exp_done = 1;
        end else if (t.ack > 63) begin
            t.exp_err = 1'b1; t.exp_done = 64;
        end else begin
            t.exp_err = 1'b0; t.exp_done = t.ack + 1 + (t.rw ? 0 : sum + 8);
        end
        return t;
    endfunction

    task automatic run_txn(input txn_t t, input string nm);
        int c = 0, gcnt = 0, att = 0, len = 0, splits_left = t.split_n, rd_j = 0, gap_left;
        int done_c = -1, bad = 0, exp_len;
        bit granted = 0, sw = 0, prev_util = 0, seen_done = 0, got_err = 0;
        logic [31:0] bits = 0, aadd = 0, full;
        logic [7:0] got_rd = 0;
        gap_left = int'(t.gaps[1:0]);
        @(negedge CLK);
        REQ = 1; RW = t.rw; SLV_ID = t.slv; MEM_ADDR = t.addr; WDATA = t.wdata;
        GRANT = 0; SPLIT = 0; S_ACK = 0; S_DIN = 0; S_DVALID = 0;
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            @(negedge CLK);
            // Garbage on the request side while busy must be ignored.
            REQ = ($urandom_range(0, 3) == 0); RW = 1'($urandom); SLV_ID = 2'($urandom);
            MEM_ADDR = 12'($urandom); WDATA = 8'($urandom);
            if (!BUSY) bad++;
            if (B_UTIL) begin
                if (!prev_util) begin
                    att++; len = 0; bits = 0; aadd = 0; granted = 1; sw = 0;
                end
                bits |= 32'(B_BUS_OUT) << len;
                aadd |= 32'(A_ADD) << len;
                if (B_MODE !== t.rw || !B_BREQ) bad++;
                if (len == 2 && splits_left > 0) begin
                    sw = 1; splits_left--;
                end
                len++;
            end else if (prev_util) begin
                c = 0;
                if (B_BREQ !== !sw) bad++;
                if (sw) begin
                    granted = 0; gcnt = 0;
                end
            end else begin
                c++;
            end
            prev_util = B_UTIL;
            if (DONE) begin
                seen_done = 1; done_c = c; got_err = ERR; got_rd = RDATA; REQ = 0;
            end
            GRANT = granted ? 1'($urandom) : (B_BREQ && gcnt >= t.gdelay);
            if (!granted && B_BREQ) gcnt++;
            if (sw) SPLIT = B_UTIL || (c < t.hold);
            else    SPLIT = (B_UTIL && len != 3) ? 1'($urandom) : 1'b0;
            S_ACK = 0; S_DVALID = 0; S_DIN = 1'($urandom);
            if (granted && !B_UTIL && !sw && !seen_done) begin
                if (c == t.ack) begin
                    S_ACK = 1;
                end else if (!t.rw && t.ack <= 63 && c > t.ack && rd_j < 8) begin
                    if (gap_left > 0) begin
                        gap_left--;
                    end else begin
                        S_DVALID = 1; S_DIN = t.rdat[rd_j[2:0]]; rd_j++;
                        if (rd_j < 8) gap_left = int'((t.gaps >> (2 * rd_j)) & 16'd3);
                    end
                end
            end
        end
        GRANT = 0; SPLIT = 0; S_ACK = 0; S_DVALID = 0; REQ = 0;
        exp_len = (t.split_n >= RetryMax) ? 3 : (t.rw ? 22 : 14);
        full = {10'd0, t.wdata, t.addr, t.slv} & ((32'd1 << exp_len) - 32'd1);
        chk({nm, " done_seen"}, 32'(seen_done), 32'd1);
        chk({nm, " attempts"}, att, (t.split_n >= RetryMax) ? RetryMax : t.split_n + 1);
        chk({nm, " util_len"}, len, exp_len);
        chk({nm, " bits"}, bits, full);
        chk({nm, " a_add"}, aadd, 32'h3);
        chk({nm, " err"}, 32'(got_err), 32'(t.exp_err));
        chk({nm, " done_cycle"}, done_c, t.exp_done);
        chk({nm, " protocol"}, bad, 0);
        if (!t.rw && !t.exp_err) chk({nm, " rdata"}, 32'(got_rd), 32'(t.rdat));
        @(negedge CLK);
        chk({nm, " after_done"}, {30'd0, DONE, BUSY}, 32'd0);
    endtask

    txn_t tbl[8];
    txn_t t;

    initial begin
        tbl[0] = mk(1, 2'd2, 12'hA5C, 8'h3C, 8'h00, 3, 1,   0, 0, 16'h0000, 0, 2);
        tbl[1] = mk(0, 2'd3, 12'h123, 8'h00, 8'h96, 1, 2,   0, 0, 16'h6349, 0, 21);
        tbl[2] = mk(1, 2'd1, 12'h0F0, 8'hA5, 8'h00, 2, 0,   1, 5, 16'h0000, 0, 1);
        tbl[3] = mk(1, 2'd1, 12'h0F0, 8'hA5, 8'h00, 2, 0,   3, 5, 16'h0000, 1, 1);
        tbl[4] = mk(1, 2'd2, 12'h7FF, 8'hFF, 8'h00, 0, 200, 0, 0, 16'h0000, 1, 64);
        tbl[5] = mk(1, 2'd3, 12'h001, 8'h80, 8'h00, 1, 63,  0, 0, 16'h0000, 0, 64);
        tbl[6] = mk(0, 2'd2, 12'hFFF, 8'h00, 8'h55, 0, 200, 0, 0, 16'h0000, 1, 64);
        tbl[7] = mk(0, 2'd1, 12'h800, 8'h00, 8'h5A, 2, 63,  0, 0, 16'h0000, 0, 72);

        RSTN = 0; REQ = 0; RW = 0; SLV_ID = 0; MEM_ADDR = 0; WDATA = 0;
        GRANT = 0; SPLIT = 0; S_ACK = 0; S_DIN = 0; S_DVALID = 0;
        repeat (3) @(negedge CLK);
        chk("reset_state", {19'd0, B_BREQ, B_UTIL, A_ADD, B_BUS_OUT, B_MODE, RDATA, DONE, ERR,
            BUSY}, 32'd0);
        RSTN = 1;

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Missing slave: immediate error, bus never requested.
        @(negedge CLK);
        REQ = 1; SLV_ID = 2'd0; RW = 1;
        @(negedge CLK);
        REQ = 0;
        chk("noslv done_err", {30'd0, DONE, ERR}, 32'h3);
        chk("noslv breq_busy", {30'd0, B_BREQ, BUSY}, 32'h0);
        @(negedge CLK);
        chk("noslv pulse", {30'd0, DONE, B_BREQ}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            t.rw = 1'($urandom); t.slv = 2'($urandom_range(1, 3));
            t.addr = 12'($urandom); t.wdata = 8'($urandom); t.rdat = 8'($urandom);
            t.gdelay = $urandom_range(0, 4);
            t.ack = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 9);
            t.split_n = (t.slv == 2'd1) ? $urandom_range(0, 3) : 0;
            t.hold = $urandom_range(0, 6); t.gaps = 16'($urandom);
            t = model(t);
            run_txn(t, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of the address phase.
        @(negedge CLK);
        REQ = 1; RW = 1; SLV_ID = 2'd2; MEM_ADDR = 12'h3C3; WDATA = 8'h81;
        @(negedge CLK);
        REQ = 0; GRANT = 1;
        begin
            int n = 0;
            for (int cyc = 0; cyc < 50 && n < 4; cyc++) begin
                @(negedge CLK);
                if (B_UTIL && !A_ADD) n++;
            end
            chk("rst reached_addr", n, 4);
        end
        #1 RSTN = 0;
        #1 chk("rst async_clear", {19'd0, B_BREQ, B_UTIL, A_ADD, B_BUS_OUT, B_MODE, RDATA, DONE,
            ERR, BUSY}, 32'd0);
        GRANT = 0;
        repeat (2) @(negedge CLK);
        RSTN = 1;
        @(negedge CLK);
        chk("rst idle", {30'd0, BUSY, B_BREQ}, 32'd0);
        t = model(mk(1, 2'd3, 12'hB71, 8'hE4, 8'h00, 1, 4, 0, 0, 16'h0, 0, 0));
        run_txn(t, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_master_tx.md
Name: bus_master_tx

Overview:
- Initiator-side serial bus port: the transmit end of the serial address/select protocol that the slave address decoder receives.
- Accepts a parallel transaction from the local master and requests the bus from the arbiter.
- Once granted, it serialises the 2-bit slave ID (address phase), then the memory address, then the write data. For reads it deserialises the returned data.
- Handles split-busy retry and an ack timeout, then reports completion or error to the local master.

Parameters:
- ADDR_W, 12, memory address bits sent after the slave ID
- DATA_W, 8, data word width
- TIMEOUT, 64, maximum cycles to wait for the slave ack/read data before error
- RETRY_MAX, 3, maximum split retries before error

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- REQ  in  1  local master transaction request; sampled in IDLE only
- RW  in  1  1=write, 0=read
- SLV_ID  in  2  target slave; 1..3 valid, 0 = no slave
- MEM_ADDR  in  ADDR_W  target address
- WDATA  in  DATA_W  write data
- GRANT  in  1  arbiter grant
- SPLIT  in  1  split-busy from decoder (target slave 1 busy)
- S_ACK  in  1  slave ack (write complete / read data start)
- S_DIN  in  1  serial read data from slave, LSB first
- S_DVALID  in  1  qualifies S_DIN
- B_BREQ  out  1  bus request to arbiter
- B_UTIL  out  1  bus-utilised / bit-valid strobe
- A_ADD  out  1  address-phase flag (slave ID bits)
- B_BUS_OUT  out  1  serial data bit, LSB first
- B_MODE  out  1  registered RW for the slave
- RDATA  out  DATA_W  captured read data
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  qualifies DONE: timeout, retry exhaustion or SLV_ID=0
- BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset (async): state IDLE, all outputs 0, RDATA 0, all counters 0.
- All outputs are registered.
- REQ latches SLV_ID, MEM_ADDR, WDATA and RW into shadow registers. Inputs may change afterwards.

State machine:
- IDLE
  - REQ with SLV_ID=0 -> DONE=1, ERR=1 for one cycle; stay in IDLE.
  - REQ with SLV_ID≠0 -> REQ_BUS.
- REQ_BUS: B_BREQ=1 until GRANT is sampled high -> SEL.
- SEL: 2 cycles. B_UTIL=1, A_ADD=1, B_BUS_OUT = shadow SLV_ID[0] then SLV_ID[1].
- ADDR: ADDR_W cycles. B_UTIL=1, A_ADD=0, B_BUS_OUT = MEM_ADDR LSB first.
  - SEL to ADDR has no gap cycle: B_UTIL stays high so the decoder keeps its select valid.
  - SPLIT is sampled in the first ADDR cycle. If SPLIT=1, abort -> SPLIT_WAIT.
- SPLIT_WAIT
  - On entry: B_UTIL, A_ADD and B_BREQ drop to 0; retry count +1.
  - retry count = RETRY_MAX -> DONE+ERR -> IDLE.
  - Otherwise wait for SPLIT=0 -> REQ_BUS.
- After ADDR: RW=1 -> WDATA, RW=0 -> RD_WAIT.
- WDATA: DATA_W cycles, B_UTIL=1, A_ADD=0, data LSB first -> ACK_WAIT.
- ACK_WAIT: B_UTIL=0, B_BREQ held 1, timeout counter runs.
  - S_ACK -> DONE (ERR=0).
  - Counter reaches TIMEOUT-1 with no ack -> DONE+ERR.
- RD_WAIT: B_UTIL=0, timeout counter runs.
  - S_ACK -> RD_DATA.
  - Timeout -> DONE+ERR.
- RD_DATA: shift S_DIN into RDATA bit[k] on each S_DVALID cycle, k = 0..DATA_W-1.
  - After DATA_W valid bits -> DONE.
  - The timeout counter restarts on each valid bit. Timeout -> DONE+ERR; RDATA keeps the partial value.
- DONE: one cycle; DONE=1, B_BREQ=0, B_UTIL=0. -> IDLE.
  - BUSY falls in the cycle after the DONE pulse.

Bus ownership:
- B_BREQ stays 1 from REQ_BUS until DONE, except in SPLIT_WAIT.
- GRANT dropping mid-transfer is ignored: the arbiter must not pre-empt.

Simultaneous events and reuse:
- S_ACK and the timeout in the same cycle: ack wins.
- SPLIT outside the first ADDR cycle is ignored.
- REQ while BUSY is ignored.
- The retry counter clears on entry to IDLE.

Reset mid-transfer:
- All outputs return to 0 immediately; the decoder sees B_UTIL=0 and clears its select.

Bit counter:
- Width is $clog2(max(ADDR_W, DATA_W)) + 1.
- Clears on every phase change; no wrap within a phase.

Timing:
- Write latency from GRANT sampled to last data bit = 2 + ADDR_W + DATA_W cycles (22 at defaults).

Test Plan:
- Write: REQ, RW=1, SLV_ID=2, MEM_ADDR=0xA5C, WDATA=0x3C; GRANT after 3 cycles; S_ACK 2 cycles after the last bit.
  - A_ADD high exactly 2 cycles with bits 0,1.
  - Then 12 address bits 0,0,1,1,1,0,1,0,0,1,0,1 and 8 data bits of 0x3C, LSB first.
  - B_UTIL continuous for 22 cycles; DONE=1, ERR=0.
- Read: SLV_ID=3, RW=0; S_ACK, then S_DIN/S_DVALID delivering 0x96 with gaps between valid bits.
  - RDATA=0x96 at DONE; ERR=0.
- Split: SLV_ID=1 with SPLIT=1 in the first ADDR cycle.
  - B_UTIL and B_BREQ drop the next cycle.
  - SPLIT cleared after 5 cycles -> re-request and full retransmission succeeds.
  - Holding SPLIT high for 3 attempts -> DONE+ERR.
- Timeout: write with no S_ACK -> DONE+ERR exactly 64 cycles after entering ACK_WAIT.
  - S_ACK arriving in the same cycle as the timeout -> ERR=0.
- Illegal/idle: SLV_ID=0 -> DONE+ERR in the next cycle with B_BREQ never asserted; REQ pulsed while BUSY -> no effect.
- Reset: assert RSTN low midway through ADDR.
  - All outputs are 0 asynchronously.
  - After release, the block is IDLE and a new transaction completes normally.
